// File: rtl/dump_loader.sv
// dump_loader: streams a cartridge dump from the sector store into the
// PRG/CHR regions of cartridge memory while holding the console in reset.
module dump_loader #(
  parameter int                ADDR_W   = 23,
  parameter logic [ADDR_W-1:0] CHR_BASE = 23'h400000
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              load_dump,
  input  logic [31:0]       dump_offset,
  input  logic [15:0]       dump_prg_len,
  input  logic [15:0]       dump_chr_len,
  output logic              sd_req,
  output logic [31:0]       sd_sector,
  input  logic              sd_ack,
  input  logic              sd_valid,
  input  logic [7:0]        sd_data,
  output logic              sd_ready,
  input  logic              sd_done,
  input  logic              sd_err,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  input  logic              mem_ack,
  output logic              loading,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    STREAM,
    CHECK,
    DONE,
    ERR
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       off_q, off_d;
  logic [15:0]       prg_q, prg_d;
  logic [15:0]       chr_q, chr_d;
  logic [15:0]       sec_q, sec_d;
  logic [15:0]       loc_q, loc_d;
  logic              phase_q, phase_d;
  logic [9:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [7:0]        dat_q, dat_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic              err_q, err_d;

  logic              accept;
  logic              full;
  logic              empty_dump;
  logic [15:0]       cur_len;
  logic [15:0]       loc_nx;
  logic [ADDR_W-1:0] base;

  assign sd_ready   = (state_q == STREAM) && !pend_q;
  assign accept     = sd_valid && sd_ready;
  assign full       = (cnt_q == 10'd512);
  assign empty_dump = (prg_q == 16'd0) && (chr_q == 16'd0);
  assign cur_len    = phase_q ? chr_q : prg_q;
  assign loc_nx     = loc_q + 16'd1;
  assign base       = phase_q ? CHR_BASE : '0;

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    prg_d   = prg_q;
    chr_d   = chr_q;
    sec_d   = sec_q;
    loc_d   = loc_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    dat_d   = dat_q;
    adr_d   = adr_q;
    if (mem_ack) pend_d = 1'b0;
    unique case (state_q)
      IDLE, ERR: begin
        if (load_dump) begin
          off_d   = dump_offset;
          prg_d   = dump_prg_len;
          chr_d   = dump_chr_len;
          sec_d   = '0;
          loc_d   = '0;
          cnt_d   = '0;
          phase_d = (dump_prg_len == 16'd0);
          // an empty dump still takes one cycle through CHECK
          if (dump_prg_len == 16'd0 && dump_chr_len == 16'd0)
            state_d = CHECK;
          else
            state_d = REQ;
        end
      end
      REQ: begin
        if (sd_err)      state_d = ERR;
        else if (sd_ack) state_d = STREAM;
      end
      STREAM: begin
        if (accept && !full) begin
          pend_d = 1'b1;
          dat_d  = sd_data;
          adr_d  = base + ADDR_W'({loc_q, 9'b0})
                 + ADDR_W'(cnt_q);
          cnt_d  = cnt_q + 10'd1;
        end
        if (sd_err || (accept && full))
          state_d = ERR;
        else if (sd_done)
          state_d = CHECK;
      end
      CHECK: begin
        if (!pend_q) begin
          if (empty_dump) begin
            state_d = DONE;
          end else if (!full) begin
            state_d = ERR;
          end else begin
            cnt_d = '0;
            sec_d = sec_q + 16'd1;
            loc_d = loc_nx;
            if (loc_nx < cur_len) begin
              state_d = REQ;
            end else if (!phase_q && chr_q != 16'd0) begin
              phase_d = 1'b1;
              loc_d   = '0;
              state_d = REQ;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    err_d = (state_d == ERR);
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      off_q   <= '0;
      prg_q   <= '0;
      chr_q   <= '0;
      sec_q   <= '0;
      loc_q   <= '0;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      dat_q   <= '0;
      adr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      prg_q   <= prg_d;
      chr_q   <= chr_d;
      sec_q   <= sec_d;
      loc_q   <= loc_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dat_q   <= dat_d;
      adr_q   <= adr_d;
      err_q   <= err_d;
    end
  end

  assign sd_req    = (state_q == REQ);
  assign sd_sector = off_q + 32'(sec_q);
  assign mem_wr    = pend_q;
  assign mem_addr  = adr_q;
  assign mem_data  = dat_q;
  assign load_done = (state_q == DONE);
  assign load_err  = err_q;
  assign loading   = (state_q == REQ)
                  || (state_q == STREAM)
                  || (state_q == ERR)
                  || ((state_q == CHECK) && !empty_dump);

endmodule
